// File: rtl/acq_peak_search_if.sv
// Stream and result bundle of the acquisition peak search: amplitude beats in, top-3 peaks,
// noise sum and status out. The master side drives the stream; the slave side is the search block.
interface acq_peak_search_if #(
    parameter int AMP_W   = 10,
    parameter int IDX_W   = 11,
    parameter int NOISE_W = 21
);
    logic               start;
    logic               amp_valid;
    logic [AMP_W-1:0]   amp_in;
    logic               amp_last;
    logic               busy;
    logic               done;
    logic [AMP_W-1:0]   peak1_amp;
    logic [IDX_W-1:0]   peak1_idx;
    logic [AMP_W-1:0]   peak2_amp;
    logic [IDX_W-1:0]   peak2_idx;
    logic [AMP_W-1:0]   peak3_amp;
    logic [IDX_W-1:0]   peak3_idx;
    logic [NOISE_W-1:0] noise_sum;
    logic               idx_ovf;

    modport master (
        output start, amp_valid, amp_in, amp_last,
        input  busy, done, peak1_amp, peak1_idx, peak2_amp, peak2_idx,
               peak3_amp, peak3_idx, noise_sum, idx_ovf
    );

    modport slave (
        input  start, amp_valid, amp_in, amp_last,
        output busy, done, peak1_amp, peak1_idx, peak2_amp, peak2_idx,
               peak3_amp, peak3_idx, noise_sum, idx_ovf
    );
endinterface

// File: rtl/acq_peak_search.sv
// Tracks the three largest bin amplitudes (with indices) over one search window; noise-floor
// sum is built only when ACQ_NOISE_SUM_EN is defined. Results land one edge after acceptance.
// No back-pressure: one sample per cycle is always accepted while searching.
module acq_peak_search #(
    parameter int AMP_W   = 10,
    parameter int IDX_W   = 11,
    parameter int NOISE_W = 21
) (
    input  logic            clk,
    input  logic            rst_b,
    acq_peak_search_if.slave bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEARCH = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    logic [1:0]       state_q,   state_d;
    logic [IDX_W-1:0] bin_cnt_q, bin_cnt_d;
    logic             idx_ovf_q, idx_ovf_d;
    logic [AMP_W-1:0] p1_amp_q, p1_amp_d, p2_amp_q, p2_amp_d, p3_amp_q, p3_amp_d;
    logic [IDX_W-1:0] p1_idx_q, p1_idx_d, p2_idx_q, p2_idx_d, p3_idx_q, p3_idx_d;
    logic             accept;

    // start wins over a same-cycle sample, so it is excluded here
    assign accept = (state_q == ST_SEARCH) && bus.amp_valid && !bus.start;

    always_comb begin
        state_d   = state_q;
        bin_cnt_d = bin_cnt_q;
        idx_ovf_d = idx_ovf_q;
        p1_amp_d  = p1_amp_q;  p1_idx_d = p1_idx_q;
        p2_amp_d  = p2_amp_q;  p2_idx_d = p2_idx_q;
        p3_amp_d  = p3_amp_q;  p3_idx_d = p3_idx_q;

        if (bus.start) begin
            state_d   = ST_SEARCH;
            bin_cnt_d = '0;
            idx_ovf_d = 1'b0;
            p1_amp_d  = '0;  p1_idx_d = '0;
            p2_amp_d  = '0;  p2_idx_d = '0;
            p3_amp_d  = '0;  p3_idx_d = '0;
        end else begin
            case (state_q)
                ST_SEARCH: if (accept && bus.amp_last) state_d = ST_FINISH;
                ST_FINISH: state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase

            if (accept) begin
                bin_cnt_d = bin_cnt_q + IDX_W'(1);
                if (&bin_cnt_q) idx_ovf_d = 1'b1;

                // strict compares: an equal amplitude never displaces an earlier bin
                if (bus.amp_in > p1_amp_q) begin
                    p3_amp_d = p2_amp_q;   p3_idx_d = p2_idx_q;
                    p2_amp_d = p1_amp_q;   p2_idx_d = p1_idx_q;
                    p1_amp_d = bus.amp_in; p1_idx_d = bin_cnt_q;
                end else if (bus.amp_in > p2_amp_q) begin
                    p3_amp_d = p2_amp_q;   p3_idx_d = p2_idx_q;
                    p2_amp_d = bus.amp_in; p2_idx_d = bin_cnt_q;
                end else if (bus.amp_in > p3_amp_q) begin
                    p3_amp_d = bus.amp_in; p3_idx_d = bin_cnt_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= ST_IDLE;
            bin_cnt_q <= '0;
            idx_ovf_q <= 1'b0;
            p1_amp_q  <= '0;  p1_idx_q <= '0;
            p2_amp_q  <= '0;  p2_idx_q <= '0;
            p3_amp_q  <= '0;  p3_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            bin_cnt_q <= bin_cnt_d;
            idx_ovf_q <= idx_ovf_d;
            p1_amp_q  <= p1_amp_d;  p1_idx_q <= p1_idx_d;
            p2_amp_q  <= p2_amp_d;  p2_idx_q <= p2_idx_d;
            p3_amp_q  <= p3_amp_d;  p3_idx_q <= p3_idx_d;
        end
    end

`ifdef ACQ_NOISE_SUM_EN
    logic [NOISE_W-1:0] noise_q, noise_d;

    always_comb begin
        noise_d = noise_q;
        if (bus.start)   noise_d = '0;
        else if (accept) noise_d = noise_q + NOISE_W'(bus.amp_in);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) noise_q <= '0;
        else        noise_q <= noise_d;
    end

    assign bus.noise_sum = noise_q;
`else
    assign bus.noise_sum = '0;
`endif

    // done is decoded straight from the state register: high exactly for the FINISH cycle
    assign bus.busy      = (state_q == ST_SEARCH);
    assign bus.done      = (state_q == ST_FINISH);
    assign bus.idx_ovf   = idx_ovf_q;
    assign bus.peak1_amp = p1_amp_q;
    assign bus.peak1_idx = p1_idx_q;
    assign bus.peak2_amp = p2_amp_q;
    assign bus.peak2_idx = p2_idx_q;
    assign bus.peak3_amp = p3_amp_q;
    assign bus.peak3_idx = p3_idx_q;
endmodule
